// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions.
//   REG_W    : default register data width
//   REG_A    : default register address width
//   WB_DEPTH : default write-back queue depth
//   wb_entry_t : one queued register write (destination address + data)
package cpu_pkg;

  localparam int REG_W    = 8;
  localparam int REG_A    = 4;
  localparam int WB_DEPTH = 4;

  typedef struct packed {
    logic [REG_A-1:0] addr;
    logic [REG_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/reg_writeback.sv
// reg_writeback: write-side front end of the register file.
// Collects result writes from the ALU and load paths into one in-order queue
// and drives the register file's single write port, one write per cycle.
// It also flags read-after-write hazards for the two decode read addresses.
//
// Ports
//   Clk, Reset_n                    clock, asynchronous active-low reset
//   AluValid/AluAddr/AluData        ALU write request
//   AluReady                        ALU request accepted this cycle
//   LdValid/LdAddr/LdData           load write request
//   LdReady                         load request accepted this cycle
//   Hold                            write port borrowed, no write issued
//   RaddrA/RaddrB                   decode read addresses (snooped)
//   HazardA/HazardB                 a queued write targets RaddrA/RaddrB
//   WriteEn/Waddr/DataIn            register file write port
//   Count                           entries currently queued
module reg_writeback
  import cpu_pkg::*;
#(
  parameter int W     = REG_W,
  parameter int A     = REG_A,
  parameter int DEPTH = WB_DEPTH
) (
  input  logic                         Clk,
  input  logic                         Reset_n,
  input  logic                         AluValid,
  input  logic [A-1:0]                 AluAddr,
  input  logic [W-1:0]                 AluData,
  output logic                         AluReady,
  input  logic                         LdValid,
  input  logic [A-1:0]                 LdAddr,
  input  logic [W-1:0]                 LdData,
  output logic                         LdReady,
  input  logic                         Hold,
  input  logic [A-1:0]                 RaddrA,
  input  logic [A-1:0]                 RaddrB,
  output logic                         HazardA,
  output logic                         HazardB,
  output logic                         WriteEn,
  output logic [A-1:0]                 Waddr,
  output logic [W-1:0]                 DataIn,
  output logic [$clog2(DEPTH+1)-1:0]   Count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [A-1:0] addr;
    logic [W-1:0] data;
  } entry_t;

  entry_t        mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] free;
  logic          alu_acc, ld_acc, pop;

  // Credit comes from the registered count only; a pop this cycle frees
  // its slot for the next cycle, which keeps Ready off the Hold path.
  assign free = CW'(DEPTH) - count_q;

  always_comb begin
    AluReady = Reset_n && (free >= CW'(1));
    // The load needs a second slot when the ALU also pushes this cycle.
    LdReady  = Reset_n && (AluValid ? (free >= CW'(2)) : (free >= CW'(1)));
  end

  assign alu_acc = AluValid && AluReady;
  assign ld_acc  = LdValid && LdReady;
  assign pop     = (count_q != '0) && !Hold;

  assign WriteEn = pop;
  assign Waddr   = (count_q != '0) ? mem_q[rd_ptr_q].addr : '0;
  assign DataIn  = (count_q != '0) ? mem_q[rd_ptr_q].data : '0;
  assign Count   = count_q;

  always_comb begin
    rd_ptr_d = rd_ptr_q + PW'(pop);
    wr_ptr_d = wr_ptr_q + PW'(alu_acc) + PW'(ld_acc);
    count_d  = count_q + CW'(alu_acc) + CW'(ld_acc) - CW'(pop);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible while counted.
  // On a dual push the ALU entry goes first to keep program order.
  always_ff @(posedge Clk) begin
    if (alu_acc) mem_q[wr_ptr_q] <= '{addr: AluAddr, data: AluData};
    if (ld_acc)  mem_q[wr_ptr_q + PW'(alu_acc)] <= '{addr: LdAddr, data: LdData};
  end

  // Compare every counted entry, head included, against both read ports.
  always_comb begin
    HazardA = 1'b0;
    HazardB = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count_q) begin
        if (mem_q[rd_ptr_q + PW'(i)].addr == RaddrA) HazardA = 1'b1;
        if (mem_q[rd_ptr_q + PW'(i)].addr == RaddrB) HazardB = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_reg_writeback.sv
// Testbench for reg_writeback: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based reference model.
module tb_reg_writeback;

  localparam int W     = 8;
  localparam int A     = 4;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);

  logic          Clk = 1'b0;
  logic          Reset_n = 1'b0;
  logic          AluValid = 1'b0, LdValid = 1'b0, Hold = 1'b0;
  logic [A-1:0]  AluAddr = '0, LdAddr = '0, RaddrA = '0, RaddrB = '0;
  logic [W-1:0]  AluData = '0, LdData = '0;
  logic          AluReady, LdReady, HazardA, HazardB, WriteEn;
  logic [A-1:0]  Waddr;
  logic [W-1:0]  DataIn;
  logic [CW-1:0] Count;

  always #5 Clk = ~Clk;

  reg_writeback #(.W(W), .A(A), .DEPTH(DEPTH)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .AluValid(AluValid), .AluAddr(AluAddr), .AluData(AluData), .AluReady(AluReady),
    .LdValid(LdValid), .LdAddr(LdAddr), .LdData(LdData), .LdReady(LdReady),
    .Hold(Hold), .RaddrA(RaddrA), .RaddrB(RaddrB),
    .HazardA(HazardA), .HazardB(HazardB),
    .WriteEn(WriteEn), .Waddr(Waddr), .DataIn(DataIn), .Count(Count)
  );

  typedef struct {
    logic [A-1:0] a;
    logic [W-1:0] d;
  } ent_t;

  ent_t         q[$];
  logic [W-1:0] rf_ref [16];
  logic [W-1:0] rf_dut [16];
  int           n_chk = 0;
  int           n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check against the model, then let
  // the model retire/enqueue at the posedge exactly as the rules dictate.
  task automatic cyc(input bit av, input logic [A-1:0] aa, input logic [W-1:0] ad,
                     input bit lv, input logic [A-1:0] la, input logic [W-1:0] ld,
                     input bit h, input logic [A-1:0] ra, input logic [A-1:0] rb,
                     output bit acc_a, output bit acc_l);
    int   cnt, free;
    bit   ea, el, ewe, ha, hb;
    ent_t e;
    @(negedge Clk);
    AluValid = av; AluAddr = aa; AluData = ad;
    LdValid  = lv; LdAddr  = la; LdData  = ld;
    Hold = h; RaddrA = ra; RaddrB = rb;
    #1;
    cnt  = q.size();
    free = DEPTH - cnt;
    ea   = Reset_n && (free >= 1);
    el   = Reset_n && (av ? (free >= 2) : (free >= 1));
    ewe  = Reset_n && (cnt != 0) && !h;
    ha = 1'b0; hb = 1'b0;
    foreach (q[i]) begin
      if (q[i].a == ra) ha = 1'b1;
      if (q[i].a == rb) hb = 1'b1;
    end
    chk("count", 32'(Count), cnt);
    chk("alu_ready", 32'(AluReady), 32'(ea));
    chk("ld_ready", 32'(LdReady), 32'(el));
    chk("write_en", 32'(WriteEn), 32'(ewe));
    if (cnt != 0) begin
      chk("waddr", 32'(Waddr), 32'(q[0].a));
      chk("data_in", 32'(DataIn), 32'(q[0].d));
    end else begin
      chk("waddr_empty", 32'(Waddr), 0);
      chk("data_in_empty", 32'(DataIn), 0);
    end
    chk("hazard_a", 32'(HazardA), 32'(ha));
    chk("hazard_b", 32'(HazardB), 32'(hb));
    if (WriteEn === 1'b1) rf_dut[Waddr] = DataIn;
    acc_a = av && ea;
    acc_l = lv && el;
    @(posedge Clk);
    if (Reset_n) begin
      if (ewe) begin
        rf_ref[q[0].a] = q[0].d;
        void'(q.pop_front());
      end
      if (acc_a) begin e.a = aa; e.d = ad; q.push_back(e); end
      if (acc_l) begin e.a = la; e.d = ld; q.push_back(e); end
    end
  endtask

  task automatic idle(input bit h, input logic [A-1:0] ra, input logic [A-1:0] rb);
    bit x, y;
    cyc(1'b0, '0, '0, 1'b0, '0, '0, h, ra, rb, x, y);
  endtask

  initial begin
    bit           xa, xl, pa, pl;
    logic [A-1:0] paa, pla;
    logic [W-1:0] pad, pld;
    int           guard;

    for (int i = 0; i < 16; i++) begin
      rf_ref[i] = '0;
      rf_dut[i] = '0;
    end

    // Reset held with a request present: nothing accepted, nothing written.
    cyc(1'b1, 4'd7, 8'h77, 1'b0, '0, '0, 1'b0, 4'd7, 4'd0, xa, xl);
    cyc(1'b1, 4'd7, 8'h77, 1'b0, '0, '0, 1'b0, 4'd7, 4'd0, xa, xl);
    #2 Reset_n = 1'b1;
    cyc(1'b1, 4'd7, 8'h77, 1'b0, '0, '0, 1'b0, 4'd7, 4'd0, xa, xl);
    chk("rst_release_accept", 32'(xa), 1);
    idle(1'b0, 4'd7, 4'd0);

    // Single ALU write into an empty queue, then hazard clears.
    cyc(1'b1, 4'd3, 8'hA5, 1'b0, '0, '0, 1'b0, 4'd3, 4'd0, xa, xl);
    idle(1'b0, 4'd3, 4'd0);
    idle(1'b0, 4'd3, 4'd0);

    // Dual push in one cycle: ALU entry drains before the load entry.
    cyc(1'b1, 4'd1, 8'h11, 1'b1, 4'd2, 8'h22, 1'b0, 4'd1, 4'd2, xa, xl);
    chk("dual_accept", 32'({xa, xl}), 32'b11);
    idle(1'b0, 4'd1, 4'd2);
    idle(1'b0, 4'd1, 4'd2);
    idle(1'b0, 4'd1, 4'd2);

    // Fill under Hold, pop one, refill at Count=3 with both valid, drain.
    cyc(1'b1, 4'd8, 8'h81, 1'b1, 4'd9, 8'h92, 1'b1, 4'd8, 4'd9, xa, xl);
    cyc(1'b1, 4'd10, 8'hA3, 1'b1, 4'd11, 8'hB4, 1'b1, 4'd10, 4'd11, xa, xl);
    cyc(1'b1, 4'd12, 8'hC5, 1'b1, 4'd13, 8'hD6, 1'b0, 4'd12, 4'd13, xa, xl);
    chk("full_no_accept", 32'({xa, xl}), 32'b00);
    cyc(1'b1, 4'd12, 8'hC5, 1'b1, 4'd13, 8'hD6, 1'b1, 4'd12, 4'd13, xa, xl);
    chk("cnt3_alu_only", 32'({xa, xl}), 32'b10);
    for (int i = 0; i < 5; i++) idle(1'b0, 4'd8, 4'd12);

    // Same destination twice: later value must win, HazardB until both retire.
    cyc(1'b1, 4'd5, 8'h01, 1'b0, '0, '0, 1'b1, 4'd0, 4'd5, xa, xl);
    cyc(1'b0, '0, '0, 1'b1, 4'd5, 8'h02, 1'b1, 4'd0, 4'd5, xa, xl);
    for (int i = 0; i < 3; i++) idle(1'b0, 4'd0, 4'd5);
    chk("same_addr_reg5", 32'(rf_dut[5]), 32'h02);

    // Asynchronous reset mid-drain: write port drops with no clock edge.
    cyc(1'b1, 4'd4, 8'h44, 1'b1, 4'd6, 8'h66, 1'b1, 4'd4, 4'd6, xa, xl);
    cyc(1'b1, 4'd14, 8'hEE, 1'b1, 4'd15, 8'hFF, 1'b1, 4'd4, 4'd6, xa, xl);
    idle(1'b0, 4'd4, 4'd6);
    #3 Reset_n = 1'b0;
    #1;
    chk("async_rst_we", 32'(WriteEn), 0);
    chk("async_rst_count", 32'(Count), 0);
    chk("async_rst_haz", 32'(HazardA), 0);
    q.delete();
    idle(1'b0, 4'd4, 4'd6);
    #2 Reset_n = 1'b1;
    for (int i = 0; i < 3; i++) idle(1'b0, 4'd4, 4'd6);

    // Randomized traffic; unaccepted requests are held unchanged.
    pa = 1'b0; pl = 1'b0;
    paa = '0; pla = '0; pad = '0; pld = '0;
    for (int n = 0; n < 400; n++) begin
      if (!pa && $urandom_range(0, 2) != 0) begin
        pa = 1'b1; paa = A'($urandom); pad = W'($urandom);
      end
      if (!pl && $urandom_range(0, 2) != 0) begin
        pl = 1'b1; pla = A'($urandom); pld = W'($urandom);
      end
      cyc(pa, paa, pad, pl, pla, pld, $urandom_range(0, 3) == 0,
          A'($urandom), A'($urandom), xa, xl);
      if (xa) pa = 1'b0;
      if (xl) pl = 1'b0;
    end

    guard = 0;
    while (q.size() != 0 && guard < 20) begin
      idle(1'b0, '0, '0);
      guard++;
    end
    chk("drain_done", 32'(q.size()), 0);
    idle(1'b0, '0, '0);

    for (int i = 0; i < 16; i++) chk($sformatf("regfile_%0d", i), 32'(rf_dut[i]), 32'(rf_ref[i]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
